// File: rtl/hex_disp_pkg.sv
// Shared types and helpers for the multiplexed hex display path.
// Combinational helpers only; no state.
package hex_disp_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int MAX_DIGITS = 32;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    // One-hot-low enable for digit idx; indices at or beyond n leave every enable off.
    function automatic logic [MAX_DIGITS-1:0] digit_enable_n(input int unsigned idx,
                                                            input int unsigned n);
        logic [MAX_DIGITS-1:0] en_n;
        en_n = '1;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i == idx && i < n) begin
                en_n[i] = 1'b0;
            end
        end
        return en_n;
    endfunction

endpackage

// File: rtl/hex_scan_driver_refresh_tick.sv
// Free-running divide-by-DIV counter; tick is high on the last count of each period.
// No backpressure: counts every cycle, synchronous active-high reset to 0.
module refresh_tick #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hex_scan_driver.sv
// Scans a NUM_DIGITS hex value onto one shared 7-segment decoder; outputs lag index by one cycle.
// Accepts one value at a time (load_ready = no value pending); the value swaps in only at a frame wrap.
module hex_scan_driver
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load_valid,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] load_data,
    output logic                           load_ready,
    output logic [NIBBLE_W-1:0]            nibble,
    output logic [NUM_DIGITS-1:0]          digit_sel_n,
    output logic                           blank,
    output logic                           frame_start
);

    localparam int DATA_W = NIBBLE_W * NUM_DIGITS;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic                  tick;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_W-1:0]     shadow_q, shadow_d;
    logic [DATA_W-1:0]     shown_q, shown_d;
    logic                  pending_q, pending_d;
    logic                  fresh_q, fresh_d;
    logic                  wrap, accept, commit;

    nibble_t               cur_nib;
    logic                  upper_zero;
    logic                  cur_blank;
    logic [NUM_DIGITS-1:0] cur_en_n;
    logic [NUM_DIGITS-1:0] cur_sel_n;

    nibble_t               nibble_q;
    logic [NUM_DIGITS-1:0] sel_n_q;
    logic                  blank_q;
    logic                  frame_start_q;

    refresh_tick #(
        .DIV (REFRESH_DIV)
    ) u_refresh_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign load_ready = !pending_q;

    always_comb begin
        idx_d     = idx_q;
        wrap      = tick && (idx_q >= LAST_IDX);
        accept    = load_valid && !pending_q;
        commit    = wrap && pending_q;
        shadow_d  = accept ? load_data : shadow_q;
        shown_d   = commit ? shadow_q : shown_q;
        pending_d = pending_q;
        // Out-of-range indices also take the wrap path, so they recover on the next tick.
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end
        if (commit) begin
            pending_d = 1'b0;
        end else if (accept) begin
            pending_d = 1'b1;
        end
        fresh_d = wrap;
    end

    always_comb begin
        cur_nib    = '0;
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == idx_q) begin
                cur_nib = shown_q[i*NIBBLE_W +: NIBBLE_W];
            end
            if (IDX_W'(i) >= idx_q && shown_q[i*NIBBLE_W +: NIBBLE_W] != '0) begin
                upper_zero = 1'b0;
            end
        end
        cur_blank = BLANK_LZ && (idx_q != '0) && upper_zero;
        cur_en_n  = NUM_DIGITS'(digit_enable_n(32'(idx_q), NUM_DIGITS));
        cur_sel_n = cur_blank ? '1 : cur_en_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q         <= '0;
            shadow_q      <= '0;
            shown_q       <= '0;
            pending_q     <= 1'b0;
            fresh_q       <= 1'b1;
            nibble_q      <= '0;
            sel_n_q       <= '1;
            blank_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            shown_q       <= shown_d;
            pending_q     <= pending_d;
            fresh_q       <= fresh_d;
            nibble_q      <= cur_nib;
            sel_n_q       <= cur_sel_n;
            blank_q       <= cur_blank;
            frame_start_q <= fresh_q;
        end
    end

    assign nibble      = nibble_q;
    assign digit_sel_n = sel_n_q;
    assign blank       = blank_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Two drivers (leading-zero blanking on and off) share one load stream; a queue holds each
// accepted value with the cycle its frame must appear, and a monitor checks every output cycle.
module tb_hex_scan_driver;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0;

    logic        rdy_a, blank_a, fs_a;
    logic [3:0]  nib_a, sel_a;
    logic        rdy_b, blank_b, fs_b;
    logic [3:0]  nib_b, sel_b;

    always #5 clk = ~clk;

    hex_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_LZ(1'b1)) dut_a (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy_a), .nibble(nib_a), .digit_sel_n(sel_a), .blank(blank_a),
        .frame_start(fs_a)
    );

    hex_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_LZ(1'b0)) dut_b (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy_b), .nibble(nib_b), .digit_sel_n(sel_b), .blank(blank_b),
        .frame_start(fs_b)
    );

    typedef struct { logic [15:0] val; logic [3:0] mask; bit b2b; } vec_t;
    typedef struct { logic [15:0] val; logic [3:0] mask; int start; } sb_t;

    vec_t        vecs [8];
    sb_t         sbq [$];
    int          cyc = 0;
    bit          in_rst = 1'b1;
    bit          busy = 1'b0;
    int          busy_end = 0;
    int          passed = 0;
    int          total = 0;
    logic [15:0] exp_val = 16'h0;
    logic [3:0]  exp_mask = 4'b1110;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
    endtask

    // Monitor: cyc counts posedges since reset was last sampled high.
    initial begin
        int         k;
        logic [3:0] one;
        logic [3:0] e_nib, e_sel;
        logic       e_bl, e_fs, e_rdy;
        one = 4'b0001;
        forever begin
            @(posedge clk);
            if (reset) begin
                in_rst = 1'b1; cyc = 0; sbq.delete(); busy = 1'b0;
                exp_val = 16'h0; exp_mask = 4'b1110;
            end else begin
                in_rst = 1'b0; cyc++;
            end
            @(negedge clk);
            #1;
            if (in_rst) begin
                check("reset_state_a", {rdy_a, nib_a, sel_a, blank_a, fs_a}, {1'b1, 4'h0, 4'hF, 1'b1, 1'b0});
                check("reset_state_b", {rdy_b, nib_b, sel_b, blank_b, fs_b}, {1'b1, 4'h0, 4'hF, 1'b1, 1'b0});
            end else begin
                if (sbq.size() > 0 && sbq[0].start == cyc) begin
                    exp_val  = sbq[0].val;
                    exp_mask = sbq[0].mask;
                    void'(sbq.pop_front());
                end
                if (busy && cyc >= busy_end) busy = 1'b0;
                k     = ((cyc - 1) / RD) % ND;
                e_nib = exp_val[4*k +: 4];
                e_bl  = exp_mask[k];
                e_sel = e_bl ? 4'hF : ~(one << k);
                e_fs  = ((cyc - 1) % FRAME == 0);
                e_rdy = !busy;
                check("scan_a", {rdy_a, nib_a, sel_a, blank_a, fs_a}, {e_rdy, e_nib, e_sel, e_bl, e_fs});
                check("scan_b", {rdy_b, nib_b, sel_b, blank_b, fs_b}, {e_rdy, e_nib, ~(one << k), 1'b0, e_fs});
            end
        end
    end

    task automatic wait_phase(input int p);
        int n = 0;
        while (cyc % FRAME != p && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("wait_phase_timeout", 32'd1, 32'd0);
    endtask

    // Holds valid until the handshake completes; returns at the negedge after the transfer edge.
    task automatic drive_load(input logic [15:0] v, input logic [3:0] m);
        int n = 0;
        bit done = 1'b0;
        load_valid = 1'b1;
        load_data  = v;
        while (!done && n < 64) begin
            if (rdy_a) begin
                @(posedge clk);
                @(negedge clk);
                busy     = 1'b1;
                busy_end = ((cyc / FRAME) + 1) * FRAME;
                sbq.push_back('{val: v, mask: m, start: busy_end + 1});
                check("ready_low_after_accept", {31'd0, rdy_a}, 32'd0);
                done = 1'b1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        load_valid = 1'b0;
        if (!done) check("load_accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sbq.size() > 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("drain_timeout", 32'd1, 32'd0);
        repeat (FRAME + 1) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{val: 16'hA3C0, mask: 4'b0000, b2b: 1'b0};
        vecs[1] = '{val: 16'h0050, mask: 4'b1100, b2b: 1'b0};
        vecs[2] = '{val: 16'h0000, mask: 4'b1110, b2b: 1'b0};
        vecs[3] = '{val: 16'h000F, mask: 4'b1110, b2b: 1'b0};
        vecs[4] = '{val: 16'h1000, mask: 4'b0000, b2b: 1'b0};
        vecs[5] = '{val: 16'h0100, mask: 4'b1000, b2b: 1'b0};
        vecs[6] = '{val: 16'h1111, mask: 4'b0000, b2b: 1'b0};
        vecs[7] = '{val: 16'h2222, mask: 4'b0000, b2b: 1'b1};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #2;
        check("first_cycle_digit0", {28'd0, nib_a}, 32'h0);
        check("first_cycle_sel", {28'd0, sel_a}, 32'hE);
        repeat (2 * FRAME + 4) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            if (!vecs[i].b2b) wait_phase(6);
            drive_load(vecs[i].val, vecs[i].mask);
        end
        wait_drain();

        // Reset while a value is pending and the index sits on digit 2.
        wait_phase(4);
        drive_load(16'h7777, 4'b0000);
        wait_phase(9);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("mid_reset_ready", {31'd0, rdy_a}, 32'd1);
        @(negedge clk);
        #2;
        check("restart_digit0", {24'd0, nib_a, sel_a}, {24'd0, 4'h0, 4'hE});
        repeat (FRAME) @(negedge clk);

        wait_phase(6);
        drive_load(16'h00B0, 4'b1100);
        wait_drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
